// File: rtl/ren_chain_pipe.sv
// ren_chain_pipe
//   Elastic chain of STAGES register slices carrying a read-enable token
//   (io_in_ren) plus a WIDTH-bit payload. Readiness ripples back from the
//   output combinationally, so a full chain still moves one token per cycle
//   when the downstream accepts.
//
//   Handshake: a token moves across a boundary on a clock edge where the
//   sender's valid and the receiver's ready are both 1. Valid never depends
//   on ready. Ready may depend on valid.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears all stages
//   io_in_ren    upstream token valid
//   io_in_data   upstream payload
//   io_in_ready  chain can take a token this cycle (0 while io_flush=1)
//   io_out_ren   last-stage token valid
//   io_out_data  last-stage payload
//   io_out_ready downstream accepts the last-stage token
//   io_flush     synchronous clear of every stage, beats any transfer
//   io_result    any stage occupied
//   io_count     number of occupied stages, 0..STAGES
module ren_chain_pipe #(
   parameter int STAGES = 4,
   parameter int WIDTH  = 8,
   localparam int CW    = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in_ren,
   input  logic [WIDTH-1:0] io_in_data,
   output logic             io_in_ready,
   output logic             io_out_ren,
   output logic [WIDTH-1:0] io_out_data,
   input  logic             io_out_ready,
   input  logic             io_flush,
   output logic             io_result,
   output logic [CW-1:0]    io_count
);

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic [STAGES-1:0] rdy;

   // A stage can take new contents when it is empty or when its own
   // contents are moving on this cycle. Walk from the output backwards.
   always_comb begin
      logic r;
      r   = io_out_ready;
      rdy = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         r      = !v_q[i] | r;
         rdy[i] = r;
      end
   end

   // Next-state for valid and payload. The payload only loads when a real
   // token arrives, so an empty slot keeps its previous (stale) value.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (rdy[0]) begin
         v_d[0] = io_in_ren;
         if (io_in_ren) begin
            d_d[0] = io_in_data;
         end
      end
      for (int i = 1; i < STAGES; i++) begin
         if (rdy[i]) begin
            v_d[i] = v_q[i-1];
            if (v_q[i-1]) begin
               d_d[i] = d_q[i-1];
            end
         end
      end
      // Flush wins over every transfer; payloads are left as don't-care.
      if (io_flush) begin
         v_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   always_comb begin
      io_count = '0;
      for (int i = 0; i < STAGES; i++) begin
         io_count = io_count + CW'(v_q[i]);
      end
   end

   assign io_in_ready = rdy[0] & !io_flush;
   assign io_out_ren  = v_q[STAGES-1];
   assign io_out_data = d_q[STAGES-1];
   assign io_result   = |v_q;

endmodule

// File: doc/ren_chain_pipe.md
REN_CHAIN_PIPE -- requirements
Module: ren_chain_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of elastic stages in the chain (legal range 1..16).
REQ-002 SHALL have parameter WIDTH, default 8, payload width carried with each read-enable token.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-005 SHALL have port io_in_ren, input, 1, upstream token valid.
REQ-006 SHALL have port io_in_data, input, WIDTH, upstream payload.
REQ-007 SHALL have port io_in_ready, output, 1, chain can accept a token this cycle.
REQ-008 SHALL have port io_out_ren, output, 1, last-stage token valid.
REQ-009 SHALL have port io_out_data, output, WIDTH, last-stage payload.
REQ-010 SHALL have port io_out_ready, input, 1, downstream accepts the token.
REQ-011 SHALL have port io_flush, input, 1, synchronous clear of all stages.
REQ-012 SHALL have port io_result, output, 1, OR of all stage valid bits (chain busy).
REQ-013 SHALL have port io_count, output, clog2(STAGES+1), number of occupied stages.

Function
REQ-014 Each stage i (0..STAGES-1) SHALL hold one register v[i] (valid) and d[i] (WIDTH-bit payload).
REQ-015 Stage readiness SHALL be rdy[i] = !v[i] | rdy[i+1], with rdy[STAGES] = io_out_ready; combinational, no bubble required.
REQ-016 io_in_ready SHALL equal rdy[0]; io_out_ren SHALL equal v[STAGES-1]; io_out_data SHALL equal d[STAGES-1].
REQ-017 Upstream transfer SHALL occur when io_in_ren & io_in_ready; stage 0 then loads io_in_data and sets v[0].
REQ-018 On a cycle with rdy[i] high, stage i SHALL load v[i-1]/d[i-1] (stage 0: io_in_ren/io_in_data); otherwise it SHALL hold.
REQ-019 Data registers SHALL load only when the incoming valid is 1; an empty slot's payload SHALL be don't-care but stable.
REQ-020 Latency with io_out_ready held high SHALL be exactly STAGES cycles from accepted input to io_out_ren=1 with the same payload.
REQ-021 Throughput SHALL be one token per cycle with io_out_ready high; tokens SHALL never be dropped, duplicated or reordered.
REQ-022 With io_out_ready low, the chain SHALL fill to STAGES tokens, then io_in_ready SHALL go low the same cycle v[0] is set and all stages are full.
REQ-023 Simultaneous downstream accept and upstream transfer on a full chain SHALL shift all stages by one, count unchanged.
REQ-024 io_flush=1 SHALL clear every v[i] at the next edge and take priority over any transfer that cycle; io_in_ready SHALL be forced 0 while io_flush=1.
REQ-025 io_result SHALL be |v[STAGES-1:0], purely combinational from registers.
REQ-026 io_count SHALL be the popcount of v[], purely combinational from registers, range 0..STAGES.
REQ-027 STAGES=1 SHALL degenerate to a single skid-free register slice with the same rules.

Reset
REQ-028 reset low SHALL immediately (asynchronously) clear all v[i] and d[i] to 0.
REQ-029 While reset is low: io_out_ren=0, io_out_data=0, io_result=0, io_count=0; io_in_ready SHALL equal io_out_ready-independent 1 (chain empty), except 0 when io_flush=1.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight tokens; first edge after release SHALL accept input normally.

Verification (STAGES=4, WIDTH=8)
REQ-031 Stream 0x11,0x22,0x33 on consecutive cycles, io_out_ready=1 -> io_out_ren high on cycles 4,5,6 with 0x11,0x22,0x33; io_count peaks at 3.
REQ-032 io_out_ready=0, io_in_ren=1 constant -> 4 tokens accepted, io_in_ready=0 from cycle 4, io_count=4, io_result=1.
REQ-033 Full chain, io_out_ready=1 and io_in_ren=1 for 6 cycles -> one token out and one in per cycle, io_count stays 4, order preserved.
REQ-034 Full chain, io_flush=1 one cycle with io_in_ren=1 -> next cycle io_count=0, io_result=0, io_out_ren=0, new token not captured.
REQ-035 Two tokens in flight, reset pulsed low mid-cycle -> outputs go 0 without a clock edge; after release, token 0xA5 emerges 4 cycles after acceptance.
REQ-036 Alternate io_out_ready 1/0 each cycle with continuous input -> no token lost or duplicated over 32 tokens (scoreboard match).
